// File: rtl/lutnet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lutnet_pkg
//  Description : Shared types and width helpers for the programmable
//                LogicNets neuron layer.
//                - lutnet_state_e : layer control states (RUN/DRAIN/SWAP)
//                - idx_width()    : neuron-index width, at least 1 bit
//                - bus_width()    : packed width of a per-neuron bus
//  Revision    : 1.0 - initial release
// ============================================================================
package lutnet_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } lutnet_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bus_width(input int n, input int bits);
    return n * bits;
  endfunction

endpackage : lutnet_pkg
`default_nettype wire

// File: rtl/lutnet_lut_bank.sv
`default_nettype none
// ============================================================================
//  Module      : lutnet_lut_bank
//  Description : Double-buffered truth table for a single neuron. The bank
//                selected by active_sel_i serves lookups; the other bank is
//                the shadow that receives configuration writes.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                active_sel_i      - 0: bank0 active, 1: bank1 active
//                we_i              - shadow write strobe (already qualified)
//                cfg_addr_i        - shadow write / readback address
//                cfg_wdata_i       - shadow write data
//                lookup_addr_i     - active-bank lookup address
//                lookup_data_o     - active-bank entry (combinational)
//                shadow_rdata_o    - shadow-bank entry at cfg_addr_i
//                                    (only with LUTNET_CFG_READBACK_EN)
//  Config      : LUTNET_CFG_READBACK_EN adds the shadow read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module lutnet_lut_bank
  import lutnet_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active_sel_i,
  input  logic                we_i,
  input  logic [IN_BITS-1:0]  cfg_addr_i,
  input  logic [OUT_BITS-1:0] cfg_wdata_i,
  input  logic [IN_BITS-1:0]  lookup_addr_i,
`ifdef LUTNET_CFG_READBACK_EN
  output logic [OUT_BITS-1:0] lookup_data_o,
  output logic [OUT_BITS-1:0] shadow_rdata_o
`else
  output logic [OUT_BITS-1:0] lookup_data_o
`endif
);

  localparam int DEPTH = 2 ** IN_BITS;

  logic [OUT_BITS-1:0] bank0_q [DEPTH];
  logic [OUT_BITS-1:0] bank1_q [DEPTH];

  // Writes always land in the bank that is not currently serving lookups.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else if (we_i) begin
      if (active_sel_i) begin
        bank0_q[cfg_addr_i] <= cfg_wdata_i;
      end else begin
        bank1_q[cfg_addr_i] <= cfg_wdata_i;
      end
    end
  end

  assign lookup_data_o = active_sel_i ? bank1_q[lookup_addr_i] : bank0_q[lookup_addr_i];

`ifdef LUTNET_CFG_READBACK_EN
  assign shadow_rdata_o = active_sel_i ? bank0_q[cfg_addr_i] : bank1_q[cfg_addr_i];
`endif

endmodule : lutnet_lut_bank
`default_nettype wire

// File: rtl/lutnet_prog_neuron_layer.sv
`default_nettype none
// ============================================================================
//  Module      : lutnet_prog_neuron_layer
//  Description : Run-time programmable LogicNets neuron layer. N_NEURONS
//                double-buffered truth tables behind a valid/ready stream
//                with one cycle of lookup latency. New tables are written
//                into the shadow banks and swapped in atomically after the
//                output register has drained.
//  Ports       : clk, rst_n                 - clock, sync active-low reset
//                in_valid/in_ready/in_data  - input sample stream
//                out_valid/out_ready/out_data - result stream
//                cfg_we/cfg_neuron/cfg_addr/cfg_wdata - shadow table write
//                cfg_commit                 - request bank swap
//                cfg_ready                  - config accepted this cycle
//                cfg_done                   - pulse in the swap cycle
//                cfg_rdata                  - registered shadow readback
//                                             (LUTNET_CFG_READBACK_EN only)
//  Config      : LUTNET_CFG_READBACK_EN adds cfg_rdata and the read mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module lutnet_prog_neuron_layer
  import lutnet_pkg::*;
#(
  parameter int IN_BITS   = 6,
  parameter int OUT_BITS  = 1,
  parameter int N_NEURONS = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [bus_width(N_NEURONS, IN_BITS)-1:0] in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [bus_width(N_NEURONS, OUT_BITS)-1:0] out_data,
  input  logic                                     cfg_we,
  input  logic [idx_width(N_NEURONS)-1:0]          cfg_neuron,
  input  logic [IN_BITS-1:0]                       cfg_addr,
  input  logic [OUT_BITS-1:0]                      cfg_wdata,
  input  logic                                     cfg_commit,
  output logic                                     cfg_ready,
`ifdef LUTNET_CFG_READBACK_EN
  output logic                                     cfg_done,
  output logic [OUT_BITS-1:0]                      cfg_rdata
`else
  output logic                                     cfg_done
`endif
);

  localparam int NIDX_W = idx_width(N_NEURONS);
  localparam int OBUS_W = bus_width(N_NEURONS, OUT_BITS);

  lutnet_state_e     state_q, state_d;
  logic              active_sel_q, active_sel_d;
  logic              out_valid_q, out_valid_d;
  logic [OBUS_W-1:0] out_data_q, out_data_d;
  logic [OBUS_W-1:0] lookup_data;
  logic              accept;

`ifdef LUTNET_CFG_READBACK_EN
  logic [OBUS_W-1:0]   shadow_rd;
  logic [OUT_BITS-1:0] rd_sel;
  logic [OUT_BITS-1:0] cfg_rdata_q;
`endif

  // --------------------------------------------------------------------------
  // Per-neuron tables. The write enable decodes the neuron index against each
  // instance, so an out-of-range index simply matches nothing.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < N_NEURONS; k++) begin : g_neuron
      logic bank_we;
      assign bank_we = cfg_we && cfg_ready && (cfg_neuron == NIDX_W'(k));

      lutnet_lut_bank #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
      ) u_bank (
        .clk           (clk),
        .rst_n         (rst_n),
        .active_sel_i  (active_sel_q),
        .we_i          (bank_we),
        .cfg_addr_i    (cfg_addr),
        .cfg_wdata_i   (cfg_wdata),
        .lookup_addr_i (in_data[k*IN_BITS +: IN_BITS]),
`ifdef LUTNET_CFG_READBACK_EN
        .lookup_data_o (lookup_data[k*OUT_BITS +: OUT_BITS]),
        .shadow_rdata_o(shadow_rd[k*OUT_BITS +: OUT_BITS])
`else
        .lookup_data_o (lookup_data[k*OUT_BITS +: OUT_BITS])
`endif
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM and handshakes
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel_q;
    cfg_ready    = (state_q == ST_RUN);
    in_ready     = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    cfg_done     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (cfg_commit) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // in_ready is low here, so the output register can only empty.
        if (!out_valid_q || out_ready) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        active_sel_d = ~active_sel_q;
        cfg_done     = 1'b1;
        state_d      = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  assign accept = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      active_sel_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      active_sel_q <= active_sel_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef LUTNET_CFG_READBACK_EN
  // Select by equality so an out-of-range neuron reads back zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (cfg_neuron == NIDX_W'(k)) begin
        rd_sel = shadow_rd[k*OUT_BITS +: OUT_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_rdata_q <= '0;
    end else begin
      cfg_rdata_q <= rd_sel;
    end
  end

  assign cfg_rdata = cfg_rdata_q;
`endif

endmodule : lutnet_prog_neuron_layer
`default_nettype wire

// File: tb/tb_lutnet_prog_neuron_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lutnet_prog_neuron_layer
//  Description : Self-checking bench for lutnet_prog_neuron_layer. Five
//                neurons are used so that neuron index 7 is encodable on the
//                3-bit cfg_neuron bus and is genuinely out of range.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lutnet_prog_neuron_layer;

  localparam int IB = 6;
  localparam int OB = 1;
  localparam int N  = 5;
  localparam int NW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*IB-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N*OB-1:0] out_data;
  logic            cfg_we;
  logic [NW-1:0]   cfg_neuron;
  logic [IB-1:0]   cfg_addr;
  logic [OB-1:0]   cfg_wdata;
  logic            cfg_commit;
  logic            cfg_ready;
  logic            cfg_done;
`ifdef LUTNET_CFG_READBACK_EN
  logic [OB-1:0]   cfg_rdata;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  lutnet_prog_neuron_layer #(
    .IN_BITS  (IB),
    .OUT_BITS (OB),
    .N_NEURONS(N)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_neuron(cfg_neuron),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_commit(cfg_commit),
    .cfg_ready (cfg_ready),
`ifdef LUTNET_CFG_READBACK_EN
    .cfg_done  (cfg_done),
    .cfg_rdata (cfg_rdata)
`else
    .cfg_done  (cfg_done)
`endif
  );

  // --------------------------------------------------------------------------
  // Reference model: two table banks per neuron, an active index, a phase
  // (0 run, 1 drain, 2 swap) and the contents of the output slot.
  // --------------------------------------------------------------------------
  logic [OB-1:0]   m_tbl [2][N][64];
  int              m_phase;
  logic            m_sel;
  logic            m_ov;
  logic [N*OB-1:0] m_od;
  logic            m_ir, m_ov_old;

  always @(posedge clk) begin
    m_ir     = (m_phase == 0) && (!m_ov || out_ready);
    m_ov_old = m_ov;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < N; k++)
          for (int a = 0; a < 64; a++) m_tbl[b][k][a] = '0;
      m_sel = 1'b0; m_ov = 1'b0; m_od = '0; m_phase = 0;
    end else begin
      if (m_phase == 0 && cfg_we && int'(cfg_neuron) < N)
        m_tbl[~m_sel][cfg_neuron][cfg_addr] = cfg_wdata;
      if (in_valid && m_ir) begin
        for (int k = 0; k < N; k++) m_od[k*OB +: OB] = m_tbl[m_sel][k][in_data[k*IB +: IB]];
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      case (m_phase)
        0: if (cfg_commit) m_phase = 1;
        1: if (!m_ov_old || out_ready) m_phase = 2;
        default: begin m_sel = ~m_sel; m_phase = 0; end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model in_ready",  32'(in_ready),  32'((m_phase == 0) && (!m_ov || out_ready)));
      chk("model out_valid", 32'(out_valid), 32'(m_ov));
      chk("model out_data",  32'(out_data),  32'(m_od));
      chk("model cfg_ready", 32'(cfg_ready), 32'(m_phase == 0));
      chk("model cfg_done",  32'(cfg_done),  32'(m_phase == 2));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present the same address to every neuron, wait for acceptance, then pin
  // the one-cycle latency and the looked-up value.
  task automatic send(input logic [IB-1:0] a, input logic [N*OB-1:0] exp, input string nm);
    int n = 0;
    in_valid = 1'b1;
    in_data  = {N{a}};
    while (!in_ready && n < 20) begin tick(); n++; end
    chk({nm, " accept"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " data"},  32'(out_data),  32'(exp));
  endtask

  task automatic cfg_write(input int nrn, input int a, input int d);
    cfg_we = 1'b1; cfg_neuron = NW'(nrn); cfg_addr = IB'(a); cfg_wdata = OB'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  // Pulse commit (together with any write already set up) and measure the
  // cycle distance from the commit cycle to cfg_done.
  task automatic commit_wait(input int exp_lat, input string nm);
    int n = 1;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cfg_we     = 1'b0;
    while (!cfg_done && n < 40) begin tick(); n++; end
    chk({nm, " done latency"}, 32'(n), 32'(exp_lat));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    tick();
    started = 1'b1;
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data",  32'(out_data),  32'd0);
    chk("reset in_ready",  32'(in_ready),  32'd1);
    chk("reset cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset cfg_done",  32'(cfg_done),  32'd0);

    // Cleared tables, back-to-back stream
    send(6'h00, 5'b00000, "zero a00");
    send(6'h3F, 5'b00000, "zero a3F");
    send(6'h15, 5'b00000, "zero a15");

    // Parity table on neuron 2
    for (int a = 0; a < 64; a++) cfg_write(2, a, int'(^a[5:0]));
    commit_wait(2, "parity");
    send(6'h07, 5'b00100, "parity a07");
    send(6'h06, 5'b00000, "parity a06");

    // Back-pressure: output held, input blocked
    tick();
    out_ready = 1'b0;
    send(6'h07, 5'b00100, "hold A");
    in_valid = 1'b1;
    in_data  = {N{6'h06}};
    for (int i = 0; i < 3; i++) begin
      chk("hold in_ready", 32'(in_ready), 32'd0);
      chk("hold out_data", 32'(out_data), 32'(5'b00100));
      tick();
    end
    out_ready = 1'b1;
    send(6'h06, 5'b00000, "release B");

    // Commit with a pending output; write during DRAIN must be dropped
    out_ready  = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    cfg_we = 1'b1; cfg_neuron = 3'd1; cfg_addr = 6'd9; cfg_wdata = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain cfg_ready", 32'(cfg_ready), 32'd0);
      chk("drain cfg_done",  32'(cfg_done),  32'd0);
      chk("drain out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!cfg_done && n < 10) begin tick(); n++; end
    chk("drain swap done", 32'(cfg_done), 32'd1);
    tick();
    send(6'h09, 5'b00000, "drain write ignored");

    // Out-of-range neuron write leaves every table untouched
    cfg_write(7, 0, 1);
    commit_wait(2, "oor");
    send(6'h00, 5'b00000, "oor a00");
    send(6'h07, 5'b00100, "oor a07");

    // Write and commit in the same cycle: write is part of the new bank
    cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_addr = 6'd5; cfg_wdata = 1'b1;
    commit_wait(2, "same-cycle");
    send(6'h05, 5'b00001, "same-cycle a05");

    // Reset in the middle of DRAIN
    out_ready  = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid-drain reset out_valid", 32'(out_valid), 32'd0);
    chk("mid-drain reset cfg_ready", 32'(cfg_ready), 32'd1);
    out_ready = 1'b1;
    send(6'h05, 5'b00000, "post reset a05");
    tick();

    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_lutnet_prog_neuron_layer
`default_nettype wire
